// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared repeat FSM encodings and counter width helpers
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } rep_st_e;

  // Bits needed to hold 0..max_val inclusive (at least one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one button channel: synchroniser, debounce, strobes, auto-repeat
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int STABLE_TK = 10,
  parameter int REP_DLY   = 50,
  parameter int REP_PER   = 10
) (
  input  logic clk,
  input  logic clr,
  input  logic tick,
  input  logic btn,
  input  logic rep_en,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int CNT_W = cnt_w(STABLE_TK);
  localparam int RC_W  = cnt_w(max2(REP_DLY, REP_PER));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TK - 1);
  localparam logic [RC_W-1:0]  DLY_LAST = RC_W'(REP_DLY - 1);
  localparam logic [RC_W-1:0]  PER_LAST = RC_W'(REP_PER - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;
  rep_st_e          st, st_nx;
  logic [RC_W-1:0]  rcnt, rcnt_nx;
  logic             rpt_nx;
  logic             accept, rise, fall;

  // A new level is accepted on the tick where it has persisted long enough.
  assign accept = tick && (s2 != level) && (cnt == CNT_LAST);
  assign rise   = accept && !level;
  assign fall   = accept && level;

  // Two-flop synchroniser for the raw pin.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Debounce counter, stable level and the press/release strobes.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      if (tick) begin
        if (s2 == level) begin
          cnt <= '0;
        end else if (accept) begin
          level <= s2;
          cnt   <= '0;
          press <= s2;
          rel   <= !s2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Repeat FSM state, tick counter and registered repeat strobe.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st   <= ST_IDLE;
      rcnt <= '0;
      rpt  <= 1'b0;
    end else begin
      st   <= st_nx;
      rcnt <= rcnt_nx;
      rpt  <= rpt_nx;
    end
  end

  // Repeat FSM next state; a falling level overrides everything (release wins).
  always_comb begin
    st_nx   = st;
    rcnt_nx = rcnt;
    rpt_nx  = 1'b0;
    if (fall) begin
      st_nx   = ST_IDLE;
      rcnt_nx = '0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (rise) begin
            st_nx   = ST_HOLD;
            rcnt_nx = '0;
          end
        end
        ST_HOLD: begin
          if (!rep_en) begin
            rcnt_nx = '0;
          end else if (tick) begin
            if (rcnt == DLY_LAST) begin
              st_nx   = ST_RPT;
              rcnt_nx = '0;
              rpt_nx  = 1'b1;
            end else begin
              rcnt_nx = rcnt + 1'b1;
            end
          end
        end
        ST_RPT: begin
          if (!rep_en) begin
            st_nx   = ST_HOLD;
            rcnt_nx = '0;
          end else if (tick) begin
            if (rcnt == PER_LAST) begin
              rcnt_nx = '0;
              rpt_nx  = 1'b1;
            end else begin
              rcnt_nx = rcnt + 1'b1;
            end
          end
        end
        default: begin
          st_nx   = ST_IDLE;
          rcnt_nx = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/debounce_rep.sv
// rtl/debounce_rep.sv - multi-channel button conditioner with shared tick prescaler
module debounce_rep
  import debounce_pkg::*;
#(
  parameter int N_CH      = 5,
  parameter int TICK_DIV  = 100000,
  parameter int STABLE_TK = 10,
  parameter int REP_DLY   = 50,
  parameter int REP_PER   = 10
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [N_CH-1:0] btn,
  input  logic [N_CH-1:0] rep_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] rel,     // release strobe; "release" is a reserved word
  output logic [N_CH-1:0] rpt
);

  localparam int PC_W = cnt_w(TICK_DIV);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(TICK_DIV - 1);

  logic [PC_W-1:0] pc;
  logic            tick;

  assign tick = (pc == PC_LAST);

  // Shared prescaler: one debounce tick every TICK_DIV clocks.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc <= '0;
    end else if (tick) begin
      pc <= '0;
    end else begin
      pc <= pc + 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .STABLE_TK (STABLE_TK),
      .REP_DLY   (REP_DLY),
      .REP_PER   (REP_PER)
    ) u_ch (
      .clk    (clk),
      .clr    (clr),
      .tick   (tick),
      .btn    (btn[i]),
      .rep_en (rep_en[i]),
      .level  (level[i]),
      .press  (press[i]),
      .rel    (rel[i]),
      .rpt    (rpt[i])
    );
  end

endmodule

// File: tb/tb_debounce_rep.sv
// tb/tb_debounce_rep.sv - self-checking bench for debounce_rep (TICK_DIV 1 and 3)
module tb_debounce_rep;

  localparam int N  = 2;
  localparam int ST = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic [N-1:0] btn = '0;
  logic [N-1:0] rep_en = '0;
  logic [N-1:0] lv1, pr1, rl1, rp1;
  logic [N-1:0] lv3, pr3, rl3, rp3;

  always #5 clk = ~clk;

  debounce_rep #(.N_CH(N), .TICK_DIV(1), .STABLE_TK(ST), .REP_DLY(RD), .REP_PER(RP)) dut1 (
    .clk(clk), .clr(clr), .btn(btn), .rep_en(rep_en),
    .level(lv1), .press(pr1), .rel(rl1), .rpt(rp1)
  );

  debounce_rep #(.N_CH(N), .TICK_DIV(3), .STABLE_TK(ST), .REP_DLY(RD), .REP_PER(RP)) dut3 (
    .clk(clk), .clr(clr), .btn(btn), .rep_en(rep_en),
    .level(lv3), .press(pr3), .rel(rl3), .rpt(rp3)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int edge_n = 0;
  int tdiv [2] = '{1, 3};

  // reference model state
  logic [N-1:0] hq[$];
  int           m_run [2][N];
  int           m_t   [2][N];
  logic [N-1:0] m_l [2];
  logic [N-1:0] m_p [2];
  logic [N-1:0] m_r [2];
  logic [N-1:0] m_q [2];

  // event log from the DUT outputs
  int fp [2][N];
  int fr [2][N];
  int np [2][N];
  int rq[$];

  function automatic void check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
    end
  endfunction

  function automatic logic [7:0] get_out(input int d);
    if (d == 0) return {lv1, pr1, rl1, rp1};
    return {lv3, pr3, rl3, rp3};
  endfunction

  function automatic void model_reset();
    hq.delete();
    edge_n = 0;
    for (int d = 0; d < 2; d++) begin
      m_l[d] = '0; m_p[d] = '0; m_r[d] = '0; m_q[d] = '0;
      for (int c = 0; c < N; c++) begin
        m_run[d][c] = 0;
        m_t[d][c]   = 0;
      end
    end
  endfunction

  function automatic void clear_log();
    rq.delete();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++) begin
        fp[d][c] = 0; fr[d][c] = 0; np[d][c] = 0;
      end
  endfunction

  // Behaviour at one rising edge: the debouncer sees the pin as it was two edges ago;
  // a level is accepted after ST consecutive disagreeing ticks; repeats fire when the
  // number of enabled ticks since press (or re-enable) hits RD, then every RP more.
  function automatic void model_step();
    logic [N-1:0] samp;
    bit tk;
    hq.push_back(btn);
    samp = (hq.size() >= 3) ? hq[hq.size() - 3] : '0;
    if (hq.size() > 3) void'(hq.pop_front());
    for (int d = 0; d < 2; d++) begin
      tk = ((edge_n % tdiv[d]) == 0);
      m_p[d] = '0; m_r[d] = '0; m_q[d] = '0;
      for (int c = 0; c < N; c++) begin
        if (tk) begin
          if (samp[c] != m_l[d][c]) begin
            m_run[d][c]++;
            if (m_run[d][c] == ST) begin
              m_l[d][c] = samp[c];
              m_run[d][c] = 0;
              if (samp[c]) m_p[d][c] = 1'b1;
              else         m_r[d][c] = 1'b1;
            end
          end else begin
            m_run[d][c] = 0;
          end
        end
        if (m_r[d][c] || m_p[d][c]) begin
          m_t[d][c] = 0;
        end else if (m_l[d][c]) begin
          if (!rep_en[c]) begin
            m_t[d][c] = 0;
          end else if (tk) begin
            m_t[d][c]++;
            if (m_t[d][c] == RD || (m_t[d][c] > RD && ((m_t[d][c] - RD) % RP) == 0))
              m_q[d][c] = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic step();
    logic [7:0] o;
    @(posedge clk);
    edge_n++;
    model_step();
    #1;
    for (int d = 0; d < 2; d++) begin
      o = get_out(d);
      check(d == 0 ? "outs_div1" : "outs_div3", int'(o),
            int'({m_l[d], m_p[d], m_r[d], m_q[d]}));
      for (int c = 0; c < N; c++) begin
        if (o[4+c]) begin
          np[d][c]++;
          if (fp[d][c] == 0) fp[d][c] = edge_n;
        end
        if (o[2+c] && fr[d][c] == 0) fr[d][c] = edge_n;
        if (d == 0 && c == 0 && o[c]) rq.push_back(edge_n);
      end
    end
  endtask

  task automatic do_reset(input bit keep_inputs);
    clr = 1'b0;
    if (!keep_inputs) begin
      btn = '0;
      rep_en = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    model_reset();
    clear_log();
    #1;
    check("reset_div1", int'(get_out(0)), 0);
    check("reset_div3", int'(get_out(1)), 0);
  endtask

  typedef struct {
    int hi_len;
    int p1;
    int r1;
    int p3;
    int r3;
  } vec_t;

  vec_t vecs[5];
  int   exp_rpt[7] = '{10, 30, 33, 36, 39, 42, 45};
  int   p;

  initial begin
    vecs[0] = '{hi_len: 1,  p1: 0, r1: 0,  p3: 0,  r3: 0};
    vecs[1] = '{hi_len: 3,  p1: 0, r1: 0,  p3: 0,  r3: 0};
    vecs[2] = '{hi_len: 4,  p1: 6, r1: 10, p3: 0,  r3: 0};
    vecs[3] = '{hi_len: 8,  p1: 6, r1: 14, p3: 0,  r3: 0};
    vecs[4] = '{hi_len: 12, p1: 6, r1: 18, p3: 12, r3: 24};

    // pulse-length table on channel 0
    foreach (vecs[i]) begin
      do_reset(1'b0);
      btn[0] = 1'b1;
      for (int k = 1; k <= 40; k++) begin
        step();
        if (k == vecs[i].hi_len) btn[0] = 1'b0;
      end
      check($sformatf("v%0d_press_div1", i), fp[0][0], vecs[i].p1);
      check($sformatf("v%0d_rel_div1", i),   fr[0][0], vecs[i].r1);
      check($sformatf("v%0d_press_div3", i), fp[1][0], vecs[i].p3);
      check($sformatf("v%0d_rel_div3", i),   fr[1][0], vecs[i].r3);
      check($sformatf("v%0d_ch1_quiet", i),  np[0][1], 0);
    end

    // hold with repeat, enable gap, then release
    do_reset(1'b0);
    rep_en = 2'b11;
    btn[0] = 1'b1;
    while (fp[0][0] == 0 && edge_n < 20) step();
    check("rep_press_edge", fp[0][0], 6);
    p = (fp[0][0] != 0) ? fp[0][0] : 6;
    while (edge_n < p + 55) begin
      step();
      if (edge_n == p + 12) rep_en[0] = 1'b0;
      if (edge_n == p + 20) rep_en[0] = 1'b1;
      if (edge_n == p + 40) btn[0] = 1'b0;
    end
    check("rep_count", rq.size(), 7);
    for (int i = 0; i < 7; i++)
      check($sformatf("rep_%0d_offset", i), (i < rq.size()) ? rq[i] - p : -1, exp_rpt[i]);
    check("rep_release_edge", fr[0][0] - p, 46);

    // simultaneous presses with a bouncing channel 1
    do_reset(1'b0);
    btn = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1 || k == 3) btn[1] = 1'b0;
      if (k == 2 || k == 4) btn[1] = 1'b1;
    end
    check("bounce_ch0_press", fp[0][0], 6);
    check("bounce_ch1_press", fp[0][1], 10);
    check("bounce_ch1_once",  np[0][1], 1);

    // asynchronous reset in the middle of repeating
    do_reset(1'b0);
    rep_en = 2'b11;
    btn = 2'b01;
    while (edge_n < 20) step();
    check("pre_clr_level", int'(lv1[0]), 1);
    clr = 1'b0;
    #1;
    check("clr_async_div1", int'(get_out(0)), 0);
    check("clr_async_div3", int'(get_out(1)), 0);
    do_reset(1'b1);
    for (int k = 1; k <= 20; k++) step();
    check("post_clr_press_div1", fp[0][0], 6);
    check("post_clr_press_div3", fp[1][0], 12);

    // randomized traffic against the reference model
    do_reset(1'b0);
    rep_en = 2'b11;
    for (int k = 0; k < 4000; k++) begin
      step();
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 11) == 0) btn[c] = ~btn[c];
        if ($urandom_range(0, 59) == 0) rep_en[c] = ~rep_en[c];
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
